iir_coeff_sched: RTL and testbench

// - Run-time coefficient controller and stream gate that sits in front of the IIR filter core.
// - Holds a writable shadow coefficient bank and an active bank; the active bank drives the core's coeff_x_i/coeff_y_i.
// - On commit, drains in-flight samples, swaps shadow->active in one cycle, then resumes traffic.
// - Coefficients therefore never change under a sample being processed.

---
 rtl/iir_coeff_sched.sv | 165 ++++++++++++++++
 tb/tb_iir_coeff_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_coeff_sched.sv
// iir_coeff_sched: shadow/active coefficient banks with drain-then-swap gating of the IIR core's input stream.
// Stream paths are zero-latency; a commit completes no earlier than 2 cycles after request. IIR_COEFF_SCHED_READBACK_EN adds a registered bank readback port.
// Upstream is blocked while draining/swapping or when MAX_INFLIGHT samples are inside the core; downstream backpressure passes straight to the core.
module iir_coeff_sched #(
  parameter int INPUT_TAPS   = 3,
  parameter int OUTPUT_TAPS  = 2,
  parameter int DATA_WIDTH   = 24,
  parameter int COEFF_WIDTH  = 18,
  parameter int MAX_INFLIGHT = 2,
  localparam int NTAPS       = INPUT_TAPS + OUTPUT_TAPS,
  localparam int ADDR_WIDTH  = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    cfg_we_i,
  input  logic [ADDR_WIDTH-1:0]                   cfg_addr_i,
  input  logic [COEFF_WIDTH-1:0]                  cfg_data_i,
  output logic                                    cfg_ready_o,
  input  logic                                    cfg_commit_i,
  output logic                                    cfg_done_o,
  output logic                                    cfg_err_o,
`ifdef IIR_COEFF_SCHED_READBACK_EN
  input  logic                                    cfg_rd_sel_i,
  output logic [COEFF_WIDTH-1:0]                  cfg_rdata_o,
`endif
  input  logic [DATA_WIDTH-1:0]                   s_data_i,
  input  logic                                    s_valid_i,
  output logic                                    s_ready_and_o,
  output logic [DATA_WIDTH-1:0]                   x_o,
  output logic                                    valid_o,
  input  logic                                    ready_and_i,
  input  logic [DATA_WIDTH-1:0]                   y_i,
  input  logic                                    iir_valid_i,
  output logic                                    iir_ready_and_o,
  output logic [DATA_WIDTH-1:0]                   m_data_o,
  output logic                                    m_valid_o,
  input  logic                                    m_ready_and_i,
  output logic [INPUT_TAPS-1:0][COEFF_WIDTH-1:0]  coeff_x_o,
  output logic [OUTPUT_TAPS-1:0][COEFF_WIDTH-1:0] coeff_y_o
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0]    MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [ADDR_WIDTH:0] NTAPS_W = (ADDR_WIDTH + 1)'(NTAPS);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [NTAPS-1:0][COEFF_WIDTH-1:0] shadow_q;
  logic [NTAPS-1:0][COEFF_WIDTH-1:0] active_q;
  logic [CNT_W-1:0]                  inflight_q, inflight_nxt;

  logic gate;
  logic accept;
  logic emit;
  logic cfg_wr;
  logic addr_ok;

  assign x_o             = s_data_i;
  assign valid_o         = s_valid_i & gate;
  assign s_ready_and_o   = ready_and_i & gate;
  assign m_data_o        = y_i;
  assign m_valid_o       = iir_valid_i;
  assign iir_ready_and_o = m_ready_and_i;

  assign accept  = valid_o & ready_and_i;
  assign emit    = iir_valid_i & m_ready_and_i;
  assign cfg_wr  = cfg_we_i & cfg_ready_o;
  assign addr_ok = {1'b0, cfg_addr_i} < NTAPS_W;

  // Saturating occupancy count; an emit at zero is a core protocol violation and is held at zero.
  always_comb begin
    inflight_nxt = inflight_q;
    if (accept && !emit) begin
      inflight_nxt = inflight_q + CNT_W'(1);
    end else if (emit && !accept && inflight_q != '0) begin
      inflight_nxt = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Leaving DRAIN on the next count lets the swap land the cycle right after the last emit.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RUN:   if (cfg_commit_i) state_nxt = ST_DRAIN;
      ST_DRAIN: if (inflight_nxt == '0) state_nxt = ST_SWAP;
      ST_SWAP:  state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    gate        = (state_q == ST_RUN) && (inflight_q < MAX_CNT);
    cfg_ready_o = (state_q != ST_SWAP);
    cfg_done_o  = (state_q == ST_SWAP);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shadow_q  <= '0;
      cfg_err_o <= 1'b0;
    end else if (cfg_wr) begin
      if (addr_ok) begin
        shadow_q[cfg_addr_i] <= cfg_data_i;
      end else begin
        cfg_err_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      active_q <= '0;
    end else if (state_q == ST_SWAP) begin
      active_q <= shadow_q;
    end
  end

  always_comb begin
    coeff_x_o = '0;
    coeff_y_o = '0;
    for (int i = 0; i < INPUT_TAPS; i++) begin
      coeff_x_o[i] = active_q[i];
    end
    for (int j = 0; j < OUTPUT_TAPS; j++) begin
      coeff_y_o[j] = active_q[INPUT_TAPS + j];
    end
  end

`ifdef IIR_COEFF_SCHED_READBACK_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cfg_rdata_o <= '0;
    end else if (!addr_ok) begin
      cfg_rdata_o <= '0;
    end else begin
      cfg_rdata_o <= cfg_rd_sel_i ? active_q[cfg_addr_i] : shadow_q[cfg_addr_i];
    end
  end
`endif

  assert property (@(posedge clk_i) disable iff (!rst_i) !(emit && inflight_q == '0));

endmodule

// File: tb/tb_iir_coeff_sched.sv
// Bench for iir_coeff_sched: a gain-only core model (y = x*coeff_x[0] >>> 15) sits behind the DUT;
// expected outputs come from a bench-side bank model and the inputs the bench itself sent.
module tb_iir_coeff_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [17:0] cfg_data = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_ready, cfg_done, cfg_err;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] x;
  logic        valid;
  logic        core_rdy = 1'b1;
  logic [23:0] y = '0;
  logic        iir_valid = 1'b0;
  logic        iir_ready;
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_rdy = 1'b1;
  logic [2:0][17:0] coeff_x;
  logic [1:0][17:0] coeff_y;

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_shadow [5];
  logic [17:0] exp_active [5];
  logic        exp_err = 1'b0;

  logic [23:0] core_q [$];
  logic [23:0] got_q [$];
  logic [23:0] sent_q [$];
  logic        acc_f = 1'b0, emi_f = 1'b0;
  logic [23:0] acc_y = '0;
  int          n_acc = 0, n_emi = 0;

  iir_coeff_sched dut (
    .clk_i(clk), .rst_i(rst_n),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .cfg_ready_o(cfg_ready), .cfg_commit_i(cfg_commit), .cfg_done_o(cfg_done), .cfg_err_o(cfg_err),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_and_o(s_ready),
    .x_o(x), .valid_o(valid), .ready_and_i(core_rdy),
    .y_i(y), .iir_valid_i(iir_valid), .iir_ready_and_o(iir_ready),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_and_i(m_rdy),
    .coeff_x_o(coeff_x), .coeff_y_o(coeff_y)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] gain(input logic [23:0] xv, input logic [17:0] c);
    logic signed [47:0] p;
    p = 48'($signed(xv)) * 48'($signed(c));
    return p[38:15];
  endfunction

  // Handshakes sampled mid-cycle, applied to the core model just after the next edge.
  always @(negedge clk) begin
    acc_f = rst_n && valid && core_rdy;
    emi_f = rst_n && iir_valid && iir_ready;
    acc_y = gain(x, coeff_x[0]);
    if (emi_f) got_q.push_back(m_data);
    if (acc_f) n_acc++;
    if (emi_f) n_emi++;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      core_q.delete();
    end else begin
      if (emi_f && core_q.size() > 0) void'(core_q.pop_front());
      if (acc_f) core_q.push_back(acc_y);
    end
    iir_valid = (core_q.size() > 0);
    y = iir_valid ? core_q[0] : '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [17:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    if (a < 3'd5) exp_shadow[a] = d; else exp_err = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_flow(input int n, input bit rand_bp);
    int sent = 0;
    int cyc = 0;
    sent_q.delete();
    got_q.delete();
    while (sent < n && cyc < 2000) begin
      s_valid  = ($urandom_range(0, 3) != 0);
      s_data   = 24'($urandom);
      m_rdy    = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      core_rdy = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (s_valid && s_ready) begin
        sent_q.push_back(s_data);
        sent++;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0; m_rdy = 1'b1; core_rdy = 1'b1;
    cyc = 0;
    while (got_q.size() < n && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin exp_shadow[i] = '0; exp_active[i] = '0; end
    exp_err = 1'b0;
    tick(); tick();
    checks++; if (coeff_x !== '0 || coeff_y !== '0) begin errors++; $display("FAIL reset_coeff: got %h/%h want 0", coeff_x, coeff_y); end
    checks++; if (cfg_err !== 1'b0 || cfg_done !== 1'b0) begin errors++; $display("FAIL reset_flags: err=%b done=%b want 0/0", cfg_err, cfg_done); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1 || s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: cfg_ready=%b s_ready=%b want 1/1", cfg_ready, s_ready); end
    tick();
  endtask

  task automatic test_flow_zero();
    run_flow(10, 1'b0);
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL flow_zero_count: got %0d want 10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
      checks++; if (got_q[i] !== gain(sent_q[i], exp_active[0])) begin errors++; $display("FAIL flow_zero_data[%0d]: got %h want %h", i, got_q[i], gain(sent_q[i], exp_active[0])); end
    end
    checks++; if (n_acc != n_emi) begin errors++; $display("FAIL flow_zero_inflight: got %0d want 0", n_acc - n_emi); end
    checks++; if (coeff_x !== '0 || coeff_y !== '0 || cfg_err !== 1'b0) begin errors++; $display("FAIL flow_zero_state: coeff %h/%h err %b want 0", coeff_x, coeff_y, cfg_err); end
  endtask

  task automatic test_shadow_write();
    cfg_write(3'd0, 18'd16384);
    for (int a = 1; a < 5; a++) cfg_write(3'(a), 18'd0);
    run_flow(8, 1'b1);
    checks++; if (coeff_x[0] !== exp_active[0]) begin errors++; $display("FAIL shadow_no_commit: coeff_x0 %0d want %0d", coeff_x[0], exp_active[0]); end
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL shadow_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
      checks++; if (got_q[i] !== gain(sent_q[i], exp_active[0])) begin errors++; $display("FAIL shadow_data[%0d]: got %h want %h", i, got_q[i], gain(sent_q[i], exp_active[0])); end
    end
  endtask

  task automatic test_commit_min();
    got_q.delete();
    cfg_commit = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL cmin_c0_done: got %b want 0", cfg_done); end
    tick();
    cfg_commit = 1'b0; s_valid = 1'b1; s_data = 24'd100;
    @(negedge clk);
    checks++; if (s_ready !== 1'b0 || valid !== 1'b0 || cfg_done !== 1'b0) begin errors++; $display("FAIL cmin_c1: s_ready=%b valid=%b done=%b want 0/0/0", s_ready, valid, cfg_done); end
    tick();
    @(negedge clk);
    checks++; if (cfg_done !== 1'b1 || s_ready !== 1'b0 || cfg_ready !== 1'b0) begin errors++; $display("FAIL cmin_c2: done=%b s_ready=%b cfg_ready=%b want 1/0/0", cfg_done, s_ready, cfg_ready); end
    checks++; if (coeff_x[0] !== exp_active[0]) begin errors++; $display("FAIL cmin_c2_coeff: got %0d want %0d", coeff_x[0], exp_active[0]); end
    for (int i = 0; i < 5; i++) exp_active[i] = exp_shadow[i];
    tick();
    @(negedge clk);
    checks++; if (cfg_done !== 1'b0 || coeff_x[0] !== 18'd16384 || s_ready !== 1'b1) begin errors++; $display("FAIL cmin_c3: done=%b coeff_x0=%0d s_ready=%b want 0/16384/1", cfg_done, coeff_x[0], s_ready); end
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 20 && got_q.size() < 1; c++) tick();
    checks++; if (got_q.size() != 1 || got_q[0] !== 24'd50) begin errors++; $display("FAIL cmin_gain: got %0d items first %0d want 1 item 50", got_q.size(), got_q.size() ? got_q[0] : 24'd0); end
  endtask

  task automatic test_commit_drain();
    logic [23:0] x0, x1;
    logic [17:0] old_c0;
    got_q.delete();
    old_c0 = exp_active[0];
    m_rdy = 1'b0;
    x0 = 24'($urandom); s_valid = 1'b1; s_data = x0;
    tick();
    s_valid = 1'b0; cfg_commit = 1'b1;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 18'h3C000;
    exp_shadow[0] = 18'h3C000;
    tick();
    cfg_commit = 1'b0; cfg_addr = 3'd1; cfg_data = 18'd77;
    exp_shadow[1] = 18'd77;
    x1 = 24'($urandom); s_valid = 1'b1; s_data = x1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (s_ready !== 1'b0 || cfg_done !== 1'b0) begin errors++; $display("FAIL drain_hold[%0d]: s_ready=%b done=%b want 0/0", c, s_ready, cfg_done); end
      tick();
      cfg_we = 1'b0;
    end
    m_rdy = 1'b1;
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL drain_emit: m_valid=%b s_ready=%b want 1/0", m_valid, s_ready); end
    tick();
    @(negedge clk);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL drain_swap_cycle: done=%b want 1", cfg_done); end
    for (int i = 0; i < 5; i++) exp_active[i] = exp_shadow[i];
    tick();
    @(negedge clk);
    checks++; if (coeff_x[0] !== exp_active[0] || coeff_x[1] !== exp_active[1] || s_ready !== 1'b1) begin errors++; $display("FAIL drain_after: c0=%h c1=%h s_ready=%b want %h/%h/1", coeff_x[0], coeff_x[1], s_ready, exp_active[0], exp_active[1]); end
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 20 && got_q.size() < 2; c++) tick();
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL drain_count: got %0d want 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== gain(x0, old_c0)) begin errors++; $display("FAIL drain_old_coeff: got %h want %h", got_q[0], gain(x0, old_c0)); end
      checks++; if (got_q[1] !== gain(x1, exp_active[0])) begin errors++; $display("FAIL drain_new_coeff: got %h want %h", got_q[1], gain(x1, exp_active[0])); end
    end
  endtask

  task automatic test_err();
    bit seen = 1'b0;
    cfg_write(3'd7, 18'd123);
    @(negedge clk);
    checks++; if (cfg_err !== exp_err) begin errors++; $display("FAIL err_set: got %b want %b", cfg_err, exp_err); end
    checks++; if (coeff_x[2] !== exp_active[2] || coeff_y !== {exp_active[4], exp_active[3]}) begin errors++; $display("FAIL err_banks: cx=%h cy=%h", coeff_x, coeff_y); end
    cfg_write(3'd2, 18'd300);
    cfg_commit = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = cfg_done;
      tick();
      cfg_commit = 1'b0;
    end
    cfg_commit = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL err_commit_done: got no done within 10 cycles want pulse"); end
    for (int i = 0; i < 5; i++) exp_active[i] = exp_shadow[i];
    @(negedge clk);
    checks++; if (coeff_x !== {exp_active[2], exp_active[1], exp_active[0]} || cfg_err !== 1'b1) begin errors++; $display("FAIL err_after_commit: cx=%h err=%b want %h/1", coeff_x, cfg_err, {exp_active[2], exp_active[1], exp_active[0]}); end
    tick();
  endtask

  task automatic test_back_to_back();
    run_flow(20, 1'b1);
    checks++; if (got_q.size() != 20) begin errors++; $display("FAIL b2b_count: got %0d want 20", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
      checks++; if (got_q[i] !== gain(sent_q[i], exp_active[0])) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[i], gain(sent_q[i], exp_active[0])); end
    end
    checks++; if (n_acc != n_emi) begin errors++; $display("FAIL b2b_inflight: got %0d want 0", n_acc - n_emi); end
  endtask

  task automatic test_reset_drain();
    m_rdy = 1'b0; s_valid = 1'b1; s_data = 24'($urandom);
    tick();
    s_valid = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b0 || cfg_done !== 1'b0) begin errors++; $display("FAIL rstd_in_drain: s_ready=%b done=%b want 0/0", s_ready, cfg_done); end
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin exp_shadow[i] = '0; exp_active[i] = '0; end
    exp_err = 1'b0;
    #1;
    checks++; if (coeff_x !== '0 || coeff_y !== '0 || cfg_err !== 1'b0 || cfg_done !== 1'b0) begin errors++; $display("FAIL rstd_async: cx=%h cy=%h err=%b done=%b want 0", coeff_x, coeff_y, cfg_err, cfg_done); end
    tick(); tick();
    rst_n = 1'b1; m_rdy = 1'b1;
    n_acc = 0; n_emi = 0;
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1 || s_ready !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL rstd_release: cfg_ready=%b s_ready=%b m_valid=%b want 1/1/0", cfg_ready, s_ready, m_valid); end
    tick();
    run_flow(6, 1'b0);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL rstd_flow_count: got %0d want 6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
      checks++; if (got_q[i] !== gain(sent_q[i], exp_active[0])) begin errors++; $display("FAIL rstd_data[%0d]: got %h want %h", i, got_q[i], gain(sent_q[i], exp_active[0])); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_flow_zero();
    test_shadow_write();
    test_commit_min();
    test_commit_drain();
    test_err();
    test_back_to_back();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
